// File: rtl/bus_read_sequencer.sv
// Read controller for the shared tri-state bus: one select low for SettleCycles ticks, capture, then TurnaroundCycles ticks all-high.
// Latency SettleCycles+TurnaroundCycles Tick-edges per read; req is ignored (not queued) whenever req_ready is low.
module bus_read_sequencer #(
    parameter int NrOfBits         = 32,
    parameter int NrOfSources      = 4,
    parameter int SelWidth         = 4,
    parameter int SettleCycles     = 1,
    parameter int TurnaroundCycles = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Tick,
    input  logic                   req,
    input  logic [SelWidth-1:0]    req_sel,
    output logic                   req_ready,
    input  logic [NrOfBits-1:0]    bus_in,
    output logic [NrOfSources-1:0] cs_n,
    output logic [NrOfBits-1:0]    rd_data,
    output logic                   rd_valid,
    output logic                   rd_err,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SettleCycles - 1);
    localparam logic [3:0] TURN_INIT   = 4'(TurnaroundCycles - 1);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [NrOfSources-1:0] cs_n_d;
    logic [NrOfBits-1:0]    rd_data_d;
    logic                   rd_valid_d;
    logic                   rd_err_d;
    logic [NrOfSources-1:0] sel_onehot;
    logic                   sel_ok;

    // Decoding against the real source list doubles as the range check.
    always_comb begin
        sel_onehot = '0;
        sel_ok     = 1'b0;
        for (int i = 0; i < NrOfSources; i++) begin
            if (req_sel == SelWidth'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_ok        = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cs_n_d     = cs_n;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        if (Tick) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (sel_ok) begin
                            cs_n_d  = ~sel_onehot;
                            cnt_d   = SETTLE_INIT;
                            state_d = SELECT;
                        end else begin
                            rd_err_d = 1'b1;
                        end
                    end
                end
                SELECT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        rd_data_d  = bus_in;
                        rd_valid_d = 1'b1;
                        cs_n_d     = '1;
                        if (TurnaroundCycles > 0) begin
                            cnt_d   = TURN_INIT;
                            state_d = RELEASE;
                        end else begin
                            cnt_d   = 4'd0;
                            state_d = IDLE;
                        end
                    end
                end
                RELEASE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    cs_n_d  = '1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Async reset on the select flops releases the bus the moment Reset rises.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            cs_n     <= '1;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cs_n     <= cs_n_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            rd_err   <= rd_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = ~req_ready;

endmodule
